// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle shared by the requesters and the arbiter
//   req   : per-source level request, driven by the requesters
//   gnt   : one-hot-or-zero grant, feeds each source's tri-state buffer OE
//   owner : index of the current (or, during turnaround, the last) owner
//   busy  : high while any grant bit is high
//   master modport is the arbiter side, slave modport is the requester side
interface bus_arbiter_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] owner;
    logic             busy;

    modport master (input req, output gnt, owner, busy);
    modport slave  (output req, input gnt, owner, busy);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin tri-state bus arbiter with turnaround gap and hold limit
//   i_clk   : system clock, all state changes on the rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : bus_arbiter_if master modport (req in; gnt, owner, busy out, all registered)
module bus_arbiter #(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 8,
    parameter int TURN     = 1,
    parameter int CNT_W    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT, TURNAROUND} state_t;

    state_t           r_state, w_state;
    logic [N-1:0]     r_gnt, w_gnt;
    logic [IDX_W-1:0] r_owner, w_owner, r_ptr, w_ptr, w_sel, w_idx;
    logic [CNT_W-1:0] r_hold, w_hold, r_turn, w_turn;
    logic             r_busy, w_found, w_release, w_arb;

    assign bus.gnt   = r_gnt;
    assign bus.owner = r_owner;
    assign bus.busy  = r_busy;

    // First set request at or after r_ptr with wrap; the loop runs downward so
    // the smallest offset from the pointer is the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = IDX_W'((int'(r_ptr) + i) % N);
            if (bus.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Owner lets go, or has used its full hold budget while someone else waits.
    assign w_release = !bus.req[r_owner] ||
                       (r_hold == CNT_W'(MAX_HOLD - 1) && |(bus.req & ~r_gnt));

    // Arbitration happens from IDLE or on the edge ending the last turnaround cycle.
    assign w_arb = r_state == IDLE || (r_state == TURNAROUND && r_turn == CNT_W'(TURN - 1));

    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_owner = r_owner;
        w_ptr   = r_ptr;
        w_hold  = r_hold;
        w_turn  = r_turn;
        if (w_arb) begin
            w_state = w_found ? GRANT : IDLE;
            w_gnt   = w_found ? (N'(1) << w_sel) : '0;
            w_owner = w_found ? w_sel : '0;
            w_hold  = '0;
        end else if (r_state == GRANT) begin
            if (w_release) begin
                w_state = TURNAROUND;
                w_gnt   = '0;
                w_turn  = '0;
                w_ptr   = (r_owner == IDX_W'(N - 1)) ? '0 : r_owner + 1'b1;
            end else if (r_hold != CNT_W'(MAX_HOLD - 1)) begin
                w_hold = r_hold + 1'b1;
            end
        end else begin
            w_turn = r_turn + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_turn  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_owner <= w_owner;
            r_ptr   <= w_ptr;
            r_hold  <= w_hold;
            r_turn  <= w_turn;
            r_busy  <= |w_gnt;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector-table and scoreboard bench for bus_arbiter (TURN=1 and TURN=3 instances)
module tb_bus_arbiter;
    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];
    vec_t t3[$];
    vec_t sb[$];
    logic [3:0] pg1 = '0;
    logic [3:0] pg3 = '0;
    int   z1 = 1;
    int   z3 = 3;

    bus_arbiter_if #(.N(4), .IDX_W(2)) bif ();
    bus_arbiter_if #(.N(4), .IDX_W(2)) bif3 ();

    bus_arbiter #(.N(4), .IDX_W(2), .MAX_HOLD(8), .TURN(1), .CNT_W(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bif)
    );
    bus_arbiter #(.N(4), .IDX_W(2), .MAX_HOLD(8), .TURN(3), .CNT_W(4)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bif3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic inv(input string nm, input logic [3:0] g, input logic [3:0] pg, input int zr, input int turn);
        n_checks++;
        if ($countones(g) > 1) begin
            n_errors++;
            $display("FAIL %s onehot: gnt=%b has more than one bit", nm, g);
        end
        if (g != 0 && pg != 0 && g != pg) begin
            n_errors++;
            $display("FAIL %s switch: gnt %b -> %b with no idle gap", nm, pg, g);
        end
        if (g != 0 && pg == 0 && zr < turn) begin
            n_errors++;
            $display("FAIL %s gap: %0d idle cycles, need %0d", nm, zr, turn);
        end
    endtask

    always @(negedge clk) begin
        inv("inv_t1", bif.gnt, pg1, z1, 1);
        inv("inv_t3", bif3.gnt, pg3, z3, 3);
        z1  = !rst_n ? 1 : (bif.gnt == 0 ? z1 + 1 : 0);
        z3  = !rst_n ? 3 : (bif3.gnt == 0 ? z3 + 1 : 0);
        pg1 = bif.gnt;
        pg3 = bif3.gnt;
    end

    task automatic add(inout vec_t q[$], input logic [3:0] r, input logic [3:0] g,
                       input logic [1:0] o, input logic b, input int n);
        vec_t v;
        v.req = r; v.gnt = g; v.owner = o; v.busy = b;
        for (int k = 0; k < n; k++) q.push_back(v);
    endtask

    task automatic run(input vec_t v, input bit d3, input string nm);
        vec_t e;
        if (d3) bif3.req = v.req;
        else    bif.req  = v.req;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({nm, "_gnt"},   d3 ? bif3.gnt   : bif.gnt,   e.gnt);
        chk({nm, "_owner"}, d3 ? bif3.owner : bif.owner, e.owner);
        chk({nm, "_busy"},  d3 ? bif3.busy  : bif.busy,  e.busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // round robin 0,1,2,3 with two grant cycles each, then wrap to 0
        add(tbl, 4'b1111, 4'b0001, 0, 1, 2);
        add(tbl, 4'b1110, 4'b0000, 0, 0, 1);
        add(tbl, 4'b1110, 4'b0010, 1, 1, 2);
        add(tbl, 4'b1100, 4'b0000, 1, 0, 1);
        add(tbl, 4'b1100, 4'b0100, 2, 1, 2);
        add(tbl, 4'b1000, 4'b0000, 2, 0, 1);
        add(tbl, 4'b1000, 4'b1000, 3, 1, 2);
        add(tbl, 4'b0001, 4'b0000, 3, 0, 1);
        add(tbl, 4'b0001, 4'b0001, 0, 1, 1);
        add(tbl, 4'b0000, 4'b0000, 0, 0, 3);
        // single requester 1 for five cycles, then idle
        add(tbl, 4'b0010, 4'b0010, 1, 1, 5);
        add(tbl, 4'b0000, 4'b0000, 1, 0, 1);
        add(tbl, 4'b0000, 4'b0000, 0, 0, 1);
        // timeout: owner 0 forced off after 8 cycles, requester 2 takes over
        add(tbl, 4'b0001, 4'b0001, 0, 1, 1);
        add(tbl, 4'b0101, 4'b0001, 0, 1, 7);
        add(tbl, 4'b0101, 4'b0000, 0, 0, 1);
        add(tbl, 4'b0101, 4'b0100, 2, 1, 2);
        add(tbl, 4'b0001, 4'b0000, 2, 0, 1);
        // lone owner holds past MAX_HOLD; a new waiter forces release at once
        add(tbl, 4'b0001, 4'b0001, 0, 1, 12);
        add(tbl, 4'b0011, 4'b0000, 0, 0, 1);
        add(tbl, 4'b0011, 4'b0010, 1, 1, 1);
        add(tbl, 4'b0000, 4'b0000, 1, 0, 1);
        add(tbl, 4'b0000, 4'b0000, 0, 0, 1);
        add(tbl, 4'b0100, 4'b0100, 2, 1, 1);
        // TURN=3 instance: three idle cycles between owners
        add(t3, 4'b0001, 4'b0001, 0, 1, 1);
        add(t3, 4'b0011, 4'b0001, 0, 1, 1);
        add(t3, 4'b0010, 4'b0000, 0, 0, 3);
        add(t3, 4'b0010, 4'b0010, 1, 1, 1);
        add(t3, 4'b0000, 4'b0000, 1, 0, 1);

        bif.req  = 4'b1111;
        bif3.req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   bif.gnt,   4'b0000);
        chk("rst_owner", bif.owner, 2'd0);
        chk("rst_busy",  bif.busy,  1'b0);
        chk("rst_gnt3",  bif3.gnt,  4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) run(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // asynchronous reset in the middle of the grant to owner 2
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_gnt",   bif.gnt,   4'b0000);
        chk("areset_owner", bif.owner, 2'd0);
        chk("areset_busy",  bif.busy,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        v.req = 4'b0110; v.gnt = 4'b0010; v.owner = 2'd1; v.busy = 1'b1;
        run(v, 1'b0, "post_reset");
        bif.req = 4'b0000;

        for (int i = 0; i < t3.size(); i++) run(t3[i], 1'b1, $sformatf("turn3_%0d", i));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
